// File: rtl/sdrm_wr_burst_pkg.sv
// rtl/sdrm_wr_burst_pkg.sv - shared widths, burst length, FSM encoding and fill-level helper
package sdrm_wr_burst_pkg;

  localparam int SDRM_DATA_W     = 36;
  localparam int SDRM_ADDR_W     = 22;
  localparam int SDRM_BURST_LEN  = 8;
  localparam int SDRM_FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } sdrm_wr_state_t;

  // A full FIFO reports usedw as 0, so the level needs one extra bit.
  function automatic logic [4:0] fill_level(input logic full, input logic [3:0] usedw);
    return full ? 5'(SDRM_FIFO_DEPTH) : {1'b0, usedw};
  endfunction

endpackage

// File: rtl/sdrm_wr_addr_gen.sv
// rtl/sdrm_wr_addr_gen.sv - ring write-address register with reload on enable rise and wrap
module sdrm_wr_addr_gen
  import sdrm_wr_burst_pkg::*;
#(
  parameter int ADDR_W    = SDRM_ADDR_W,
  parameter int BURST_LEN = SDRM_BURST_LEN
) (
  input  logic              clk_100,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              start,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] region_words,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W:0] STEP = (ADDR_W+1)'(BURST_LEN);

  logic              enable_d;
  logic              reload_pend;
  logic              reload;
  logic [ADDR_W-1:0] ring_base;
  logic [ADDR_W-1:0] ring_size;
  logic [ADDR_W:0]   next_addr;
  logic [ADDR_W:0]   ring_end;

  // Ring geometry is captured by the first burst after reset or after an enable rise.
  assign reload    = reload_pend | (enable & ~enable_d);
  assign next_addr = {1'b0, addr} + STEP;
  assign ring_end  = {1'b0, ring_base} + {1'b0, ring_size};

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      enable_d    <= 1'b0;
      reload_pend <= 1'b1;
      ring_base   <= '0;
      ring_size   <= '0;
      addr        <= '0;
    end else begin
      enable_d    <= enable;
      reload_pend <= reload & ~start;
      if (start && reload) begin
        addr      <= base_addr;
        ring_base <= base_addr;
        ring_size <= region_words;
      end else if (advance) begin
        addr <= (next_addr >= ring_end) ? ring_base : next_addr[ADDR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/sdrm_wr_burst.sv
// rtl/sdrm_wr_burst.sv - drains BURST_LEN-word bursts from sdrm_fifo into the SDRAM write port
// Optional request timeout with sticky wr_err under `SDRM_WR_TIMEOUT_EN.
module sdrm_wr_burst
  import sdrm_wr_burst_pkg::*;
#(
  parameter int DATA_W      = SDRM_DATA_W,
  parameter int ADDR_W      = SDRM_ADDR_W,
  parameter int BURST_LEN   = SDRM_BURST_LEN,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk_100,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] region_words,
  input  logic [DATA_W-1:0] fifo_q,
  input  logic [3:0]        fifo_usedw,
  input  logic              fifo_full,
  output logic              fifo_rdreq,
  output logic              sdr_wr_req,
  input  logic              sdr_wr_ack,
  output logic [ADDR_W-1:0] sdr_wr_addr,
  output logic [DATA_W-1:0] sdr_wr_data,
  output logic              sdr_wr_valid,
  output logic              sdr_wr_last,
  output logic              busy,
  output logic [15:0]       burst_cnt,
  output logic              wr_err
);

  localparam int         CW     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [4:0] BL_LVL = 5'(BURST_LEN);
  // An illegal configuration never starts a burst instead of streaming a malformed one.
  localparam bit CFG_OK = ((BURST_LEN == 1) || (BURST_LEN == 2) || (BURST_LEN == 4) ||
                           (BURST_LEN == 8) || (BURST_LEN == 16)) &&
                          (TIMEOUT_CYC >= 1) && (TIMEOUT_CYC <= 255);

  sdrm_wr_state_t state;
  logic [CW-1:0]  rd_left;
  logic [4:0]     level;
  logic           start;
  logic           advance;

  assign level       = fill_level(fifo_full, fifo_usedw);
  assign start       = CFG_OK && (state == IDLE) && enable && (level >= BL_LVL);
  assign advance     = (state == XFER) && sdr_wr_valid && sdr_wr_last;
  // FIFO q is already registered one cycle after rdreq, so it lines up with sdr_wr_valid.
  assign sdr_wr_data = sdr_wr_valid ? fifo_q : '0;

`ifdef SDRM_WR_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] to_cnt;
  logic       wr_err_q;
  assign wr_err = wr_err_q;
`else
  assign wr_err = 1'b0;
`endif

  sdrm_wr_addr_gen #(
    .ADDR_W    (ADDR_W),
    .BURST_LEN (BURST_LEN)
  ) u_addr_gen (
    .clk_100      (clk_100),
    .rst_n        (rst_n),
    .enable       (enable),
    .start        (start),
    .advance      (advance),
    .base_addr    (base_addr),
    .region_words (region_words),
    .addr         (sdr_wr_addr)
  );

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sdr_wr_req   <= 1'b0;
      fifo_rdreq   <= 1'b0;
      sdr_wr_valid <= 1'b0;
      sdr_wr_last  <= 1'b0;
      busy         <= 1'b0;
      burst_cnt    <= '0;
      rd_left      <= '0;
`ifdef SDRM_WR_TIMEOUT_EN
      to_cnt       <= '0;
      wr_err_q     <= 1'b0;
`endif
    end else begin
      sdr_wr_valid <= fifo_rdreq;
      sdr_wr_last  <= fifo_rdreq && (rd_left == '0);
      case (state)
        IDLE: begin
          if (start) begin
            state      <= REQ;
            sdr_wr_req <= 1'b1;
            busy       <= 1'b1;
`ifdef SDRM_WR_TIMEOUT_EN
            to_cnt     <= '0;
`endif
          end
        end
        REQ: begin
          if (sdr_wr_ack) begin
            state      <= XFER;
            sdr_wr_req <= 1'b0;
            fifo_rdreq <= 1'b1;
            rd_left    <= CW'(BURST_LEN - 1);
          end
`ifdef SDRM_WR_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            state      <= IDLE;
            sdr_wr_req <= 1'b0;
            busy       <= 1'b0;
            wr_err_q   <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
`endif
        end
        XFER: begin
          if (fifo_rdreq) begin
            if (rd_left == '0) fifo_rdreq <= 1'b0;
            else               rd_left    <= rd_left - 1'b1;
          end
          if (advance) begin
            state     <= IDLE;
            busy      <= 1'b0;
            burst_cnt <= burst_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdrm_wr_burst.sv
// tb/tb_sdrm_wr_burst.sv - self-checking bench for sdrm_wr_burst with a FIFO and ring-address model
module tb_sdrm_wr_burst;

  localparam int BL = 8;

  logic        clk_100;
  logic        rst_n;
  logic        enable;
  logic [21:0] base_addr;
  logic [21:0] region_words;
  logic [35:0] fifo_q;
  logic [3:0]  fifo_usedw;
  logic        fifo_full;
  logic        fifo_rdreq;
  logic        sdr_wr_req;
  logic        sdr_wr_ack;
  logic [21:0] sdr_wr_addr;
  logic [35:0] sdr_wr_data;
  logic        sdr_wr_valid;
  logic        sdr_wr_last;
  logic        busy;
  logic [15:0] burst_cnt;
  logic        wr_err;

  sdrm_wr_burst dut (
    .clk_100      (clk_100),
    .rst_n        (rst_n),
    .enable       (enable),
    .base_addr    (base_addr),
    .region_words (region_words),
    .fifo_q       (fifo_q),
    .fifo_usedw   (fifo_usedw),
    .fifo_full    (fifo_full),
    .fifo_rdreq   (fifo_rdreq),
    .sdr_wr_req   (sdr_wr_req),
    .sdr_wr_ack   (sdr_wr_ack),
    .sdr_wr_addr  (sdr_wr_addr),
    .sdr_wr_data  (sdr_wr_data),
    .sdr_wr_valid (sdr_wr_valid),
    .sdr_wr_last  (sdr_wr_last),
    .busy         (busy),
    .burst_cnt    (burst_cnt),
    .wr_err       (wr_err)
  );

  initial clk_100 = 1'b0;
  always #5 clk_100 = ~clk_100;

  int tests  = 0;
  int failed = 0;

  // FIFO model: words pushed by the stimulus, popped on rdreq with q valid one cycle later.
  logic [35:0] fifo_mem [0:1023];
  logic [35:0] exp_q [$];
  int pushed_total = 0;
  int popped_total = 0;
  int underflow    = 0;
  int lvl;

  assign lvl        = pushed_total - popped_total;
  assign fifo_full  = (lvl >= 16);
  assign fifo_usedw = (lvl >= 16) ? 4'd0 : 4'(lvl);

  always @(posedge clk_100) begin
    if (fifo_rdreq) begin
      if (popped_total < pushed_total) begin
        fifo_q       <= fifo_mem[popped_total];
        popped_total <= popped_total + 1;
      end else begin
        underflow <= underflow + 1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [35:0] v);
    fifo_mem[pushed_total] = v;
    exp_q.push_back(v);
    pushed_total++;
  endtask

  function automatic logic [35:0] rand36();
    return {4'($urandom), $urandom};
  endfunction

  // One complete burst: wait for req, ack after ack_dly cycles, then score the streamed words.
  task automatic do_burst(input int ack_dly, input logic [21:0] exp_addr, input int drop_at,
                          output int lat);
    int n, rd, vw;
    bit done;
    logic [35:0] exp_d;
    n = 0;
    do begin
      @(negedge clk_100);
      n++;
    end while (!sdr_wr_req && n < 40);
    lat = n;
    check("req asserted", sdr_wr_req, 1'b1);
    check("burst addr", sdr_wr_addr, exp_addr);
    check("no rdreq during req", fifo_rdreq, 1'b0);
    repeat (ack_dly) @(negedge clk_100);
    check("addr stable", sdr_wr_addr, exp_addr);
    sdr_wr_ack = 1'b1;
    @(negedge clk_100);
    sdr_wr_ack = 1'b0;
    check("req drop after ack", sdr_wr_req, 1'b0);
    check("rdreq after ack", fifo_rdreq, 1'b1);
    rd = 0;
    vw = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (fifo_rdreq) rd++;
      if (sdr_wr_valid) begin
        if (vw == 0) check("valid latency", c, 1);
        vw++;
        exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check("wr data", sdr_wr_data, exp_d);
        check("wr last", sdr_wr_last, (vw == BL));
        if (vw == drop_at) enable = 1'b0;
      end
      if (!busy) done = 1'b1;
      else @(negedge clk_100);
    end
    check("burst finished", done, 1'b1);
    check("rdreq count", rd, BL);
    check("valid count", vw, BL);
    check("idle gap", sdr_wr_req, 1'b0);
  endtask

  typedef struct {
    int          n_push;
    int          first_val;
    int          step;
    int          ack_dly;
    bit          exp_req;
    logic [21:0] exp_addr;
    int          exp_cnt;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int lat, exp_cnt, nb, rb, rr, hi;
    bit saw;

    tbl[0] = '{7, 34, 3, 0, 1'b0, 22'h000, 0};
    tbl[1] = '{1, 55, 0, 2, 1'b1, 22'h100, 1};
    tbl[2] = '{8, -1, 0, 0, 1'b1, 22'h108, 2};
    tbl[3] = '{8, -1, 0, 5, 1'b1, 22'h110, 3};
    tbl[4] = '{8, -1, 0, 1, 1'b1, 22'h118, 4};
    tbl[5] = '{8, -1, 0, 3, 1'b1, 22'h100, 5};

    rst_n        = 1'b0;
    enable       = 1'b0;
    sdr_wr_ack   = 1'b0;
    base_addr    = 22'h100;
    region_words = 22'd32;
    repeat (2) @(negedge clk_100);
    check("rst busy", busy, 1'b0);
    check("rst req", sdr_wr_req, 1'b0);
    check("rst rdreq", fifo_rdreq, 1'b0);
    check("rst valid", sdr_wr_valid, 1'b0);
    check("rst last", sdr_wr_last, 1'b0);
    check("rst data", sdr_wr_data, 36'h0);
    check("rst addr", sdr_wr_addr, 22'h0);
    check("rst burst_cnt", burst_cnt, 16'h0);
    check("rst wr_err", wr_err, 1'b0);
    rst_n  = 1'b1;
    enable = 1'b1;

    for (int i = 0; i < 6; i++) begin
      for (int w = 0; w < tbl[i].n_push; w++)
        push(tbl[i].first_val < 0 ? rand36() : 36'(tbl[i].first_val + w * tbl[i].step));
      if (!tbl[i].exp_req) begin
        saw = 1'b0;
        repeat (20) begin
          @(negedge clk_100);
          if (sdr_wr_req || fifo_rdreq || busy) saw = 1'b1;
        end
        check("idle below burst len", saw, 1'b0);
      end else begin
        do_burst(tbl[i].ack_dly, tbl[i].exp_addr, 0, lat);
        check("req latency", lat, 1);
      end
      check("table burst_cnt", burst_cnt, 16'(tbl[i].exp_cnt));
    end
    exp_cnt = 5;

    // Full FIFO (usedw reads 0): two back-to-back bursts, ring reloaded by the enable rise.
    enable = 1'b0;
    @(negedge clk_100);
    for (int w = 0; w < 16; w++) push(rand36());
    enable = 1'b1;
    do_burst(1, 22'h100, 0, lat);
    do_burst(0, 22'h108, 0, lat);
    check("b2b second latency", lat, 1);
    exp_cnt += 2;
    check("full burst_cnt", burst_cnt, 16'(exp_cnt));
    check("fifo drained", lvl, 0);

    // Enable dropped on the 3rd word: burst completes, then no new request.
    enable = 1'b0;
    @(negedge clk_100);
    for (int w = 0; w < 16; w++) push(rand36());
    enable = 1'b1;
    do_burst(2, 22'h100, 3, lat);
    saw = 1'b0;
    repeat (20) begin
      @(negedge clk_100);
      if (sdr_wr_req || busy) saw = 1'b1;
    end
    check("no req after disable", saw, 1'b0);
    check("level left after disable", lvl, 8);
    enable = 1'b1;
    do_burst(0, 22'h100, 0, lat);
    exp_cnt += 2;
    check("drop burst_cnt", burst_cnt, 16'(exp_cnt));

    // Random rings: address of burst i is base + (i*BL mod region).
    rb = 0;
    rr = BL;
    nb = 0;
    for (int r = 0; r < 6; r++) begin
      enable = 1'b0;
      @(negedge clk_100);
      rb           = int'($urandom_range(0, 22'h1FFFFF));
      rr           = BL * int'($urandom_range(1, 4));
      base_addr    = 22'(rb);
      region_words = 22'(rr);
      enable       = 1'b1;
      nb           = int'($urandom_range(1, 6));
      for (int i = 0; i < nb; i++) begin
        for (int w = 0; w < BL; w++) push(rand36());
        do_burst(int'($urandom_range(0, 4)), 22'(rb + (i * BL) % rr), 0, lat);
        exp_cnt++;
        check("rand burst_cnt", burst_cnt, 16'(exp_cnt));
      end
    end

`ifdef SDRM_WR_TIMEOUT_EN
    for (int w = 0; w < BL; w++) push(rand36());
    hi = 0;
    while (!sdr_wr_req && hi < 40) begin
      @(negedge clk_100);
      hi++;
    end
    check("timeout req seen", sdr_wr_req, 1'b1);
    hi  = 0;
    saw = 1'b0;
    while (sdr_wr_req && hi < 400) begin
      if (fifo_rdreq) saw = 1'b1;
      hi++;
      @(negedge clk_100);
    end
    check("timeout req cycles", hi, 255);
    check("timeout wr_err", wr_err, 1'b1);
    check("timeout no rdreq", saw, 1'b0);
    do_burst(1, 22'(rb + (nb * BL) % rr), 0, lat);
    exp_cnt++;
    check("retry burst_cnt", burst_cnt, 16'(exp_cnt));
    check("wr_err sticky", wr_err, 1'b1);
`else
    hi = 0;
    check("wr_err tied low", wr_err, 1'b0);
`endif

    // Reset in the middle of a transfer aborts immediately.
    for (int w = 0; w < BL; w++) push(rand36());
    hi = 0;
    while (!sdr_wr_req && hi < 40) begin
      @(negedge clk_100);
      hi++;
    end
    sdr_wr_ack = 1'b1;
    @(negedge clk_100);
    sdr_wr_ack = 1'b0;
    repeat (2) @(negedge clk_100);
    check("mid-burst active", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async reset outputs", {busy, sdr_wr_req, fifo_rdreq, sdr_wr_valid, sdr_wr_last}, 5'b0);
    check("async reset burst_cnt", burst_cnt, 16'h0);
    enable = 1'b0;
    @(negedge clk_100);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_100);
    check("idle after reset", {busy, sdr_wr_req, fifo_rdreq}, 3'b0);
    check("fifo underflow", underflow, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, failed);
    $fatal(1);
  end

endmodule

// File: doc/sdrm_wr_burst.md
Name: sdrm_wr_burst

Overview:
- Downstream consumer of sdrm_fifo, in the clk_100 domain.
- Watches the FIFO fill level. When at least BURST_LEN words are buffered, it requests an SDRAM write burst, drains exactly BURST_LEN words from the FIFO and streams them to the SDRAM controller write port.
- Keeps a write address that advances per burst and wraps inside a programmable ring region.

Parameters:
- DATA_W, 36, FIFO q width and SDRAM write data width.
- ADDR_W, 22, SDRAM word address width.
- BURST_LEN, 8, words per burst; power of two, 1..16.
- TIMEOUT_CYC, 255, ack timeout in cycles; used only when SDRM_WR_TIMEOUT_EN is defined.

Ports:
- clk_100  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  allows new bursts to start.
- base_addr  in  ADDR_W  ring start address; sampled only in IDLE.
- region_words  in  ADDR_W  ring size in words; multiple of BURST_LEN, nonzero.
- fifo_q  in  DATA_W  FIFO read data; normal mode, valid 1 cycle after rdreq.
- fifo_usedw  in  4  FIFO fill level.
- fifo_full  in  1  FIFO full; when set, usedw reads 0 and the fill level is 16.
- fifo_rdreq  out  1  FIFO read strobe.
- sdr_wr_req  out  1  burst request to SDRAM controller.
- sdr_wr_ack  in  1  controller accepts the request.
- sdr_wr_addr  out  ADDR_W  burst start address; stable while sdr_wr_req is high.
- sdr_wr_data  out  DATA_W  write data.
- sdr_wr_valid  out  1  sdr_wr_data valid.
- sdr_wr_last  out  1  final word of the burst.
- busy  out  1  high in any state other than IDLE.
- burst_cnt  out  16  completed bursts; wraps at 65535.
- wr_err  out  1  sticky timeout flag; tied 0 when the macro is absent.

Behaviour:
- Reset (async, rst_n=0): all outputs 0; state=IDLE; internal addr=0. Asserting reset mid-burst aborts the burst immediately; no recovery of the words already drained.
- Fill level: level = fifo_full ? 16 : fifo_usedw.
- IDLE:
  - If enable && level >= BURST_LEN: addr_reg<=cur_addr (first burst after reset or after enable rise uses base_addr), go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - sdr_wr_req=1 and sdr_wr_addr=addr_reg, both registered.
  - On sdr_wr_ack: drop sdr_wr_req next cycle, go to XFER.
- XFER:
  - fifo_rdreq=1 for exactly BURST_LEN consecutive cycles.
  - sdr_wr_valid follows fifo_rdreq one cycle later, with sdr_wr_data=fifo_q.
  - sdr_wr_last=1 on the BURST_LEN-th valid word.
  - After the last valid word, go to IDLE. burst_cnt increments the same cycle.
- Latency:
  - IDLE->REQ: 1 cycle after the condition is met.
  - ack->first rdreq: 1 cycle.
  - first rdreq->first valid: 1 cycle.
  - IDLE is revisited for at least 1 cycle between bursts.
- Address update at end of burst: next = addr_reg + BURST_LEN; if next >= base_addr + region_words, next = base_addr. Compute with ADDR_W+1 bits so the compare has no overflow.
- enable deasserted mid-burst: the current burst completes, then the block stays in IDLE. The next enable rise reloads base_addr.
- base_addr/region_words changes take effect only at the enable rise.
- FIFO empty during XFER cannot occur, because level was checked before starting. fifo_rdreq is never asserted while level < remaining words.
- sdr_wr_ack outside REQ is ignored.

Optional Feature:
- Macro: SDRM_WR_TIMEOUT_EN.
- Defined:
  - An 8-bit counter runs in REQ.
  - If TIMEOUT_CYC cycles pass without sdr_wr_ack: drop sdr_wr_req, set wr_err (sticky until reset), return to IDLE without reading the FIFO. The address is unchanged and the burst is retried on the next IDLE pass.
- Undefined: REQ waits indefinitely; wr_err is constant 0 and no counter is built.

Decomposition:
- Shared package/include (defination.v): SDRM_BUS, data width, address width, burst length and the state encodings IDLE/REQ/XFER.
- One natural sub-module, sdrm_wr_addr_gen: ring address register, load, advance and wrap logic.

Test Plan:
- Reset, then write 7 words to the FIFO with enable=1 -> no sdr_wr_req, fifo_rdreq stays 0, busy=0.
- base_addr=0x100, region=32, write 8 words 34,37,...,55, ack 2 cycles after req -> sdr_wr_addr=0x100. 8 rdreq pulses, then 8 valid words 34..55 with last on 55. burst_cnt=1.
- Fill the FIFO to 16 (full=1, usedw=0), enable=1 -> two back-to-back bursts at 0x100 and 0x108 with an IDLE gap of at least 1 cycle; FIFO drained to 0.
- Four bursts with base=0x100, region=32 -> addresses 0x100, 0x108, 0x110, 0x118, then the fifth is 0x100.
- Drop enable during the 3rd word of XFER -> all 8 words are delivered, then busy=0 and no further req despite FIFO level >= 8.
- With SDRM_WR_TIMEOUT_EN defined, never ack -> req drops after 255 cycles, wr_err=1, no rdreq. Ack the retry -> the burst uses the same address.
